csc_frame_arbiter: RTL and testbench
====================================

Name: csc_frame_arbiter

Overview:
- Shares one RGB-to-YUV colour-space converter between two independent RGB pixel streams, such as two imager channels.
- Arbitration is at frame granularity: a whole frame from one source is forwarded, then the block re-arbitrates round-robin.
- Frames that arrive while the converter is busy are dropped whole and counted.
- Sits directly upstream of the converter. It drives the converter's dvi/dtype/r/g/b/meta and enable inputs and tags each frame with its source.

Parameters:
PIXEL_WIDTH, 8, width of each r/g/b component
TIMEOUT, 4096, idle cycles inside a granted frame before a forced frame end
CNT_WIDTH, 16, width of each saturating drop counter
FS_DTYPE, `DTYPE_FRAME_START, dtype value marking frame start
FE_DTYPE, `DTYPE_FRAME_END, dtype value marking frame end

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous active-high reset
src_en  in  2  per-source enable; sampled only in IDLE
csc_en  in  2  per-source converter enable (0 = bypass) forwarded with the grant
dvi0/dvi1  in  1  source data valid
dtypei0/dtypei1  in  `DTYPE_WIDTH  source dtype
r0,g0,b0 / r1,g1,b1  in  PIXEL_WIDTH each  source pixels
meta_datai0/meta_datai1  in  16  source metadata
dvo  out  1  valid to converter
dtypeo  out  `DTYPE_WIDTH  dtype to converter
r,g,b  out  PIXEL_WIDTH each  pixels to converter
meta_datao  out  16  metadata to converter
conv_enable  out  1  converter enable for the current frame
sel  out  1  source index of the current/last granted frame
busy  out  1  a frame is being forwarded
timeout_evt  out  1  one-cycle pulse when a forced frame end is issued
drop_cnt0/drop_cnt1  out  CNT_WIDTH  dropped-frame counters, saturating

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, rr_last=1 (source 0 wins first tie), drop counters 0, drop flags clear, timeout counter 0.
- Every output is registered. Forwarded beats appear exactly 1 cycle after the input beat.
- A frame start is dvi_n=1 with dtypei_n==FS_DTYPE. A frame end is dvi_n=1 with dtypei_n==FE_DTYPE.
- States: IDLE, PASS0, PASS1.
- IDLE: dvo=0. On a frame start from an enabled source n, go to PASSn. In the same cycle, forward that frame-start beat (it appears next cycle) and latch sel=n and conv_enable=csc_en[n].
  - If both enabled sources start in the same cycle, grant the source != rr_last. The other source is dropped.
  - Frame starts from disabled sources are ignored and not counted.
- PASSn: forward every dvi_n beat unchanged (dtype, pixels, meta). busy=1.
  - On source n's frame end: forward the beat, set rr_last=n, and return to IDLE next cycle.
  - A frame start can arrive in the first IDLE cycle after the frame end and is granted there with no gap cycle.
- Drop: a frame start from the other enabled source while in PASSn sets drop_flag_m, and drop_cnt_m increments by 1, saturating at all-ones.
  - All source-m beats are discarded until m's frame end clears drop_flag_m.
  - A source with drop_flag set cannot be granted, even if PASSn ends first.
- Timeout: in PASSn the counter increments on each cycle with dvi_n=0 and resets on dvi_n=1.
  - On reaching TIMEOUT: emit one beat with dvo=1, dtypeo=FE_DTYPE, pixels 0, meta 0; pulse timeout_evt; go to IDLE.
  - Source n is then treated as dropping until its own frame end arrives.
- A beat of source n with dtype != FS_DTYPE while in IDLE is ignored.
- src_en changes take effect only in IDLE. A deasserted enable never aborts a granted frame.
- conv_enable and sel hold their values through IDLE until the next grant.
- Reset mid-frame: outputs drop to 0 immediately. After release, both sources must present a new frame start; no partial frames are forwarded.

Test Plan:
- src_en=01, source 0 sends FS, 4 pixels (r=10..13), FE -> identical 6 beats on outputs, each 1 cycle later; sel=0; busy for 6 cycles; drop_cnt0=0.
- src_en=11, both FS in same cycle after reset -> source 0 granted, drop_cnt1=1, no source-1 beats forwarded. A repeat after source 0's FE -> source 1 granted.
- Source 1 FS arrives 2 cycles into a source-0 frame; source 0 ends first; source 1 keeps streaming -> source 1 stays dropped until its FE, then its next FS is granted.
- Granted source stalls with TIMEOUT=8 -> after 8 idle cycles, one dvo beat with dtypeo=FE_DTYPE and timeout_evt=1, then IDLE; that source's late FE is ignored.
- csc_en=10, frames from source 0 then source 1 -> conv_enable=0 during frame 0, 1 during frame 1; CNT_WIDTH=2 with 5 drops -> drop counter saturates at 3.
- Assert reset mid-frame -> dvo=0 and busy=0 at once (no clock needed); remaining pixels without a new FS -> nothing forwarded.

Source files
------------

// File: rtl/csc_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one RGB-to-YUV converter between two pixel sources.
// Losing or late frames are dropped whole. Stalled frames are closed by a timeout.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif

module csc_frame_arbiter #(
    parameter int                      PIXEL_WIDTH = 8,
    parameter int                      TIMEOUT     = 4096,
    parameter int                      CNT_WIDTH   = 16,
    parameter logic [`DTYPE_WIDTH-1:0] FS_DTYPE    = `DTYPE_FRAME_START,
    parameter logic [`DTYPE_WIDTH-1:0] FE_DTYPE    = `DTYPE_FRAME_END
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              src_en,
    input  logic [1:0]              csc_en,
    input  logic                    dvi0,
    input  logic                    dvi1,
    input  logic [`DTYPE_WIDTH-1:0] dtypei0,
    input  logic [`DTYPE_WIDTH-1:0] dtypei1,
    input  logic [PIXEL_WIDTH-1:0]  r0,
    input  logic [PIXEL_WIDTH-1:0]  g0,
    input  logic [PIXEL_WIDTH-1:0]  b0,
    input  logic [PIXEL_WIDTH-1:0]  r1,
    input  logic [PIXEL_WIDTH-1:0]  g1,
    input  logic [PIXEL_WIDTH-1:0]  b1,
    input  logic [15:0]             meta_datai0,
    input  logic [15:0]             meta_datai1,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [PIXEL_WIDTH-1:0]  r,
    output logic [PIXEL_WIDTH-1:0]  g,
    output logic [PIXEL_WIDTH-1:0]  b,
    output logic [15:0]             meta_datao,
    output logic                    conv_enable,
    output logic                    sel,
    output logic                    busy,
    output logic                    timeout_evt,
    output logic [CNT_WIDTH-1:0]    drop_cnt0,
    output logic [CNT_WIDTH-1:0]    drop_cnt1,
    output logic [1:0]              dbg_state
);
    // Streams are valid-only: a beat transfers on every cycle its dvi is high.
    // There is no ready, so neither source nor the converter can apply backpressure.

    localparam int              DW       = `DTYPE_WIDTH;
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS0 = 2'd1,
        ST_PASS1 = 2'd2
    } state_t;

    logic [1:0]             src_dvi;
    logic [DW-1:0]          src_dtype [2];
    logic [PIXEL_WIDTH-1:0] src_r     [2];
    logic [PIXEL_WIDTH-1:0] src_g     [2];
    logic [PIXEL_WIDTH-1:0] src_b     [2];
    logic [15:0]            src_meta  [2];

    assign src_dvi      = {dvi1, dvi0};
    assign src_dtype[0] = dtypei0;
    assign src_dtype[1] = dtypei1;
    assign src_r[0]     = r0;
    assign src_r[1]     = r1;
    assign src_g[0]     = g0;
    assign src_g[1]     = g1;
    assign src_b[0]     = b0;
    assign src_b[1]     = b1;
    assign src_meta[0]  = meta_datai0;
    assign src_meta[1]  = meta_datai1;

    state_t                 state_q, state_d;
    logic                   rr_last_q, rr_last_d;
    logic [1:0]             drop_flag_q, drop_flag_d;
    logic [1:0]             en_q, en_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                   dvo_q, dvo_d;
    logic [DW-1:0]          dtype_q, dtype_d;
    logic [PIXEL_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [15:0]            meta_q, meta_d;
    logic                   conv_en_q, conv_en_d;
    logic                   sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic                   tevt_q, tevt_d;

    logic [1:0] fs, fe, cand, drop_inc;
    logic       win, cur, oth, fwd, fwd_src;

    always_comb begin
        fs          = {src_dvi[1] && (src_dtype[1] == FS_DTYPE), src_dvi[0] && (src_dtype[0] == FS_DTYPE)};
        fe          = {src_dvi[1] && (src_dtype[1] == FE_DTYPE), src_dvi[0] && (src_dtype[0] == FE_DTYPE)};
        cand        = 2'b00;
        drop_inc    = 2'b00;
        win         = 1'b0;
        cur         = 1'b0;
        oth         = 1'b0;
        fwd         = 1'b0;
        fwd_src     = 1'b0;
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        drop_flag_d = drop_flag_q & ~fe;
        en_d        = en_q;
        tmo_d       = tmo_q;
        dvo_d       = 1'b0;
        dtype_d     = '0;
        r_d         = '0;
        g_d         = '0;
        b_d         = '0;
        meta_d      = '0;
        conv_en_d   = conv_en_q;
        sel_d       = sel_q;
        busy_d      = 1'b0;
        tevt_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                en_d = src_en;
                cand = fs & src_en & ~drop_flag_q;
                if (cand != 2'b00) begin
                    // On a tie the source that finished last yields and loses its frame.
                    if (cand == 2'b11) begin
                        win                    = ~rr_last_q;
                        drop_flag_d[rr_last_q] = 1'b1;
                        drop_inc[rr_last_q]    = 1'b1;
                    end else begin
                        win = cand[1];
                    end
                    state_d   = win ? ST_PASS1 : ST_PASS0;
                    sel_d     = win;
                    conv_en_d = csc_en[win];
                    tmo_d     = '0;
                    busy_d    = 1'b1;
                    fwd       = 1'b1;
                    fwd_src   = win;
                end
            end
            ST_PASS0, ST_PASS1: begin
                cur    = (state_q == ST_PASS1);
                oth    = ~cur;
                busy_d = 1'b1;
                if (fs[oth] && en_q[oth]) begin
                    drop_flag_d[oth] = 1'b1;
                    drop_inc[oth]    = 1'b1;
                end
                if (src_dvi[cur]) begin
                    fwd     = 1'b1;
                    fwd_src = cur;
                    tmo_d   = '0;
                    if (fe[cur]) begin
                        state_d   = ST_IDLE;
                        rr_last_d = cur;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Synthesised frame end; the stalled source must finish its frame before regrant.
                    dvo_d            = 1'b1;
                    dtype_d          = FE_DTYPE;
                    tevt_d           = 1'b1;
                    drop_flag_d[cur] = 1'b1;
                    rr_last_d        = cur;
                    tmo_d            = '0;
                    state_d          = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fwd) begin
            dvo_d   = 1'b1;
            dtype_d = src_dtype[fwd_src];
            r_d     = src_r[fwd_src];
            g_d     = src_g[fwd_src];
            b_d     = src_b[fwd_src];
            meta_d  = src_meta[fwd_src];
        end

        cnt0_d = cnt0_q;
        if (drop_inc[0] && (cnt0_q != {CNT_WIDTH{1'b1}})) cnt0_d = cnt0_q + 1'b1;
        cnt1_d = cnt1_q;
        if (drop_inc[1] && (cnt1_q != {CNT_WIDTH{1'b1}})) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 1'b1;
            drop_flag_q <= 2'b00;
            en_q        <= 2'b00;
            tmo_q       <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            dvo_q       <= 1'b0;
            dtype_q     <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            meta_q      <= '0;
            conv_en_q   <= 1'b0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            tevt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            drop_flag_q <= drop_flag_d;
            en_q        <= en_d;
            tmo_q       <= tmo_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            dvo_q       <= dvo_d;
            dtype_q     <= dtype_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            meta_q      <= meta_d;
            conv_en_q   <= conv_en_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            tevt_q      <= tevt_d;
        end
    end

    assign dvo         = dvo_q;
    assign dtypeo      = dtype_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign meta_datao  = meta_q;
    assign conv_enable = conv_en_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign timeout_evt = tevt_q;
    assign drop_cnt0   = cnt0_q;
    assign drop_cnt1   = cnt1_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_csc_frame_arbiter.sv
// Bench for csc_frame_arbiter: directed scenarios then random traffic,
// each cycle compared against a frame-level reference model.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif

module tb_csc_frame_arbiter;
    localparam int TMO = 8;
    localparam int CW  = 2;
    localparam logic [`DTYPE_WIDTH-1:0] DT_FS  = `DTYPE_FRAME_START;
    localparam logic [`DTYPE_WIDTH-1:0] DT_FE  = `DTYPE_FRAME_END;
    localparam logic [`DTYPE_WIDTH-1:0] DT_PX  = 4'h0;
    localparam logic [`DTYPE_WIDTH-1:0] DT_OTH = 4'h7;
    localparam int K_NONE = 0, K_FS = 1, K_PX = 2, K_FE = 3, K_OTH = 4;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]              src_en = 2'b00;
    logic [1:0]              csc_en = 2'b00;
    logic                    dvi [2];
    logic [`DTYPE_WIDTH-1:0] dt  [2];
    logic [7:0]              pr  [2];
    logic [7:0]              pg  [2];
    logic [7:0]              pb  [2];
    logic [15:0]             pm  [2];

    logic                    dvo, conv_enable, sel, busy, timeout_evt;
    logic [`DTYPE_WIDTH-1:0] dtypeo;
    logic [7:0]              r, g, b;
    logic [15:0]             meta_datao;
    logic [CW-1:0]           drop_cnt0, drop_cnt1;
    logic [1:0]              dbg_state;

    csc_frame_arbiter #(.PIXEL_WIDTH(8), .TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .src_en(src_en), .csc_en(csc_en),
        .dvi0(dvi[0]), .dvi1(dvi[1]), .dtypei0(dt[0]), .dtypei1(dt[1]),
        .r0(pr[0]), .g0(pg[0]), .b0(pb[0]), .r1(pr[1]), .g1(pg[1]), .b1(pb[1]),
        .meta_datai0(pm[0]), .meta_datai1(pm[1]),
        .dvo(dvo), .dtypeo(dtypeo), .r(r), .g(g), .b(b), .meta_datao(meta_datao),
        .conv_enable(conv_enable), .sel(sel), .busy(busy), .timeout_evt(timeout_evt),
        .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // reference model: who owns the converter, who is mid-drop, and what the next output beat must be
    int                      m_owner;
    int                      m_rr;
    bit                      m_drop [2];
    int                      m_cnt  [2];
    int                      m_idle;
    logic [1:0]              m_en;
    logic                    m_sel, m_conv;
    logic                    e_dvo, e_busy, e_tevt;
    logic [`DTYPE_WIDTH-1:0] e_dt;
    logic [7:0]              e_r, e_g, e_b;
    logic [15:0]             e_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1; m_rr = 1; m_idle = 0; m_en = 2'b00; m_sel = 1'b0; m_conv = 1'b0;
        for (int k = 0; k < 2; k++) begin m_drop[k] = 1'b0; m_cnt[k] = 0; end
    endfunction

    function automatic void count_drop(input int k);
        m_drop[k] = 1'b1;
        if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
    endfunction

    function automatic void copy_beat(input int k);
        e_dvo = 1'b1; e_dt = dt[k]; e_r = pr[k]; e_g = pg[k]; e_b = pb[k]; e_m = pm[k];
    endfunction

    function automatic void model_step();
        bit fs [2];
        bit fe [2];
        int n, w, o;
        for (int k = 0; k < 2; k++) begin
            fs[k] = dvi[k] && (dt[k] == DT_FS);
            fe[k] = dvi[k] && (dt[k] == DT_FE);
        end
        e_dvo = 0; e_dt = '0; e_r = '0; e_g = '0; e_b = '0; e_m = '0; e_busy = 0; e_tevt = 0;
        for (int k = 0; k < 2; k++) if (fe[k]) m_drop[k] = 1'b0;
        if (m_owner < 0) begin
            m_en = src_en;
            n = 0; w = -1;
            for (int k = 0; k < 2; k++) if (fs[k] && src_en[k] && !m_drop[k]) begin n++; w = k; end
            if (n == 2) begin
                w = 1 - m_rr;
                count_drop(m_rr);
            end
            if (w >= 0) begin
                m_owner = w; m_sel = w[0]; m_conv = csc_en[w]; m_idle = 0; e_busy = 1;
                copy_beat(w);
            end
        end else begin
            o = 1 - m_owner;
            e_busy = 1;
            if (fs[o] && m_en[o]) count_drop(o);
            if (dvi[m_owner]) begin
                copy_beat(m_owner);
                m_idle = 0;
                if (fe[m_owner]) begin m_rr = m_owner; m_owner = -1; end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    e_dvo = 1; e_dt = DT_FE; e_tevt = 1;
                    m_drop[m_owner] = 1'b1; m_rr = m_owner; m_owner = -1; m_idle = 0;
                end
            end
        end
    endfunction

    // driver tasks
    task automatic set_src(input int k, input int kind, input logic [7:0] px);
        dvi[k] = (kind != K_NONE);
        case (kind)
            K_FS:    dt[k] = DT_FS;
            K_FE:    dt[k] = DT_FE;
            K_OTH:   dt[k] = DT_OTH;
            default: dt[k] = DT_PX;
        endcase
        pr[k] = px;
        pg[k] = px ^ 8'h5a;
        pb[k] = px + 8'd3;
        pm[k] = {4'ha, 3'b000, k[0], px};
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("dvo", 64'(dvo), 64'(e_dvo));
        check("dtypeo", 64'(dtypeo), 64'(e_dt));
        check("r", 64'(r), 64'(e_r));
        check("g", 64'(g), 64'(e_g));
        check("b", 64'(b), 64'(e_b));
        check("meta", 64'(meta_datao), 64'(e_m));
        check("busy", 64'(busy), 64'(e_busy));
        check("timeout_evt", 64'(timeout_evt), 64'(e_tevt));
        check("conv_enable", 64'(conv_enable), 64'(m_conv));
        check("sel", 64'(sel), 64'(m_sel));
        check("drop_cnt0", 64'(drop_cnt0), 64'(m_cnt[0]));
        check("drop_cnt1", 64'(drop_cnt1), 64'(m_cnt[1]));
        check("granted_state", 64'(dbg_state != 2'd0), 64'(m_owner >= 0));
    endtask

    task automatic beat2(input int k0, input logic [7:0] p0, input int k1, input logic [7:0] p1);
        set_src(0, k0, p0);
        set_src(1, k1, p1);
        step();
    endtask

    // asserted asynchronously; outputs must clear before any clock edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_dvo", 64'(dvo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_conv", 64'(conv_enable), 64'd0);
        check("rst_cnt0", 64'(drop_cnt0), 64'd0);
        check("rst_cnt1", 64'(drop_cnt1), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int pick();
        int v;
        v = $urandom_range(0, 99);
        if (v < 7)  return K_FS;
        if (v < 14) return K_FE;
        if (v < 55) return K_PX;
        if (v < 60) return K_OTH;
        return K_NONE;
    endfunction

    initial begin
        int quiet;
        set_src(0, K_NONE, 8'd0);
        set_src(1, K_NONE, 8'd0);
        model_reset();
        do_reset();

        // single source frame: FS, four pixels, FE
        src_en = 2'b01;
        beat2(K_FS, 8'd0, K_NONE, 8'd0);
        for (int i = 10; i <= 13; i++) beat2(K_PX, 8'(i), K_NONE, 8'd0);
        beat2(K_FE, 8'd0, K_NONE, 8'd0);
        check("t1_sel", 64'(sel), 64'd0);
        beat2(K_NONE, 8'd0, K_NONE, 8'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // simultaneous starts after reset, then a repeat after source 0 finishes
        do_reset();
        src_en = 2'b11;
        beat2(K_FS, 8'd1, K_FS, 8'd2);
        beat2(K_PX, 8'd20, K_PX, 8'd30);
        beat2(K_PX, 8'd21, K_FE, 8'd0);
        beat2(K_FE, 8'd0, K_NONE, 8'd0);
        check("t2_drop1", 64'(drop_cnt1), 64'd1);
        beat2(K_FS, 8'd3, K_FS, 8'd4);
        check("t2_sel1", 64'(sel), 64'd1);
        beat2(K_FE, 8'd0, K_FE, 8'd0);
        beat2(K_NONE, 8'd0, K_NONE, 8'd0);

        // late start from source 1 stays dropped after source 0 ends
        beat2(K_FS, 8'd5, K_NONE, 8'd0);
        beat2(K_PX, 8'd50, K_NONE, 8'd0);
        beat2(K_PX, 8'd51, K_FS, 8'd6);
        beat2(K_FE, 8'd0, K_PX, 8'd60);
        beat2(K_NONE, 8'd0, K_PX, 8'd61);
        check("t3_dropped_idle", 64'(dvo), 64'd0);
        beat2(K_NONE, 8'd0, K_PX, 8'd62);
        beat2(K_NONE, 8'd0, K_FE, 8'd0);
        beat2(K_NONE, 8'd0, K_FS, 8'd7);
        check("t3_regrant", 64'(sel), 64'd1);
        beat2(K_NONE, 8'd0, K_PX, 8'd70);
        beat2(K_NONE, 8'd0, K_FE, 8'd0);

        // stall of the granted source
        src_en = 2'b01;
        beat2(K_FS, 8'd8, K_NONE, 8'd0);
        beat2(K_PX, 8'd80, K_NONE, 8'd0);
        for (int i = 0; i < TMO; i++) beat2(K_NONE, 8'd0, K_NONE, 8'd0);
        check("t4_tevt", 64'(timeout_evt), 64'd1);
        check("t4_fe", 64'(dtypeo), 64'(DT_FE));
        beat2(K_NONE, 8'd0, K_NONE, 8'd0);
        beat2(K_FE, 8'd0, K_NONE, 8'd0);
        check("t4_late_fe", 64'(dvo), 64'd0);
        beat2(K_FS, 8'd9, K_NONE, 8'd0);
        beat2(K_FE, 8'd0, K_NONE, 8'd0);

        // per-frame converter enable and saturating drop counter
        do_reset();
        src_en = 2'b11;
        csc_en = 2'b10;
        beat2(K_FS, 8'd11, K_NONE, 8'd0);
        check("t5_conv0", 64'(conv_enable), 64'd0);
        beat2(K_FE, 8'd0, K_NONE, 8'd0);
        beat2(K_NONE, 8'd0, K_FS, 8'd12);
        check("t5_conv1", 64'(conv_enable), 64'd1);
        beat2(K_NONE, 8'd0, K_FE, 8'd0);
        for (int i = 0; i < 5; i++) begin
            beat2(K_FS, 8'(i), K_NONE, 8'd0);
            beat2(K_PX, 8'(i + 40), K_FS, 8'd0);
            beat2(K_PX, 8'(i + 41), K_FE, 8'd0);
            beat2(K_FE, 8'd0, K_NONE, 8'd0);
        end
        check("t5_sat", 64'(drop_cnt1), 64'd3);

        // reset in the middle of a frame
        src_en = 2'b01;
        beat2(K_FS, 8'd1, K_NONE, 8'd0);
        beat2(K_PX, 8'd2, K_NONE, 8'd0);
        set_src(0, K_PX, 8'd3);
        do_reset();
        beat2(K_PX, 8'd4, K_NONE, 8'd0);
        beat2(K_PX, 8'd5, K_NONE, 8'd0);
        beat2(K_FE, 8'd0, K_NONE, 8'd0);
        check("t6_no_partial", 64'(dvo), 64'd0);

        // random traffic
        src_en = 2'b11;
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            int k0, k1;
            if ($urandom_range(0, 149) == 0) src_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) csc_en = 2'($urandom_range(0, 3));
            if (quiet == 0 && $urandom_range(0, 79) == 0) quiet = $urandom_range(4, 12);
            if (quiet > 0) begin
                quiet--;
                k0 = K_NONE;
                k1 = K_NONE;
            end else begin
                k0 = pick();
                k1 = pick();
            end
            beat2(k0, 8'($urandom_range(0, 255)), k1, 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
